// File: rtl/uart_result_sender_pkg.sv
// Definitions shared by the result sender and its byte serializer.
package uart_result_sender_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_LEN,
    ST_FETCH,
    ST_RD_WAIT,
    ST_HI,
    ST_LO,
    ST_CSUM,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_IDLE,
    ST_DONE
  } state_t;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  // Start bit + 8 data bits + stop bit.
  localparam int FRAME_BITS = 10;

  // Clock cycles per UART bit.
  function automatic int bit_period(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_result_sender_tx.sv
// 8N1 UART serializer: one byte per tx_start, LSB first, line idles high.
module uart_result_sender_tx
  import uart_result_sender_pkg::*;
#(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       tx_busy
);

  localparam int BIT_CYC = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int TW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  logic [9:0]    shreg;
  logic [TW-1:0] timer;
  logic [3:0]    bit_cnt;

  // Bit timer counts down to zero, then the next bit is shifted onto the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '1;
      timer   <= '0;
      bit_cnt <= '0;
      tx_busy <= 1'b0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        shreg   <= {1'b1, data_in, 1'b0};
        timer   <= TW'(BIT_CYC - 1);
        bit_cnt <= '0;
        tx_busy <= 1'b1;
      end
    end else if (timer == '0) begin
      shreg <= {1'b1, shreg[9:1]};
      timer <= TW'(BIT_CYC - 1);
      if (bit_cnt == 4'(FRAME_BITS - 1)) begin
        tx_busy <= 1'b0;
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else begin
      timer <= timer - TW'(1);
    end
  end

  assign tx = shreg[0];

endmodule

// File: rtl/uart_result_sender.sv
// Streams a block of result words out of the UART as a framed packet:
// header, length, data bytes (MSB first per word), XOR checksum.
//
// state      | meaning
// IDLE       | waiting for start
// HDR        | load header byte
// LEN        | load length byte, fold into checksum
// FETCH      | strobe rd_en at current address
// RD_WAIT    | capture rd_data into word register
// HI         | load word high byte
// LO         | load word low byte, advance address/count
// CSUM       | load checksum byte
// ISSUE      | pulse serializer start once it is free
// WAIT_BUSY  | wait for serializer to accept the byte
// WAIT_IDLE  | wait for stop bit to finish, then go to return state
// DONE       | one-cycle done pulse
module uart_result_sender
  import uart_result_sender_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state, next_state, ret_state;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_next;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        csum;
  logic [7:0]        byte_r;
  logic [DATA_W-1:0] word_r;
  logic              ser_start;
  logic              ser_busy;

  assign cnt_next = cnt + CNT_ONE;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state and strobe decode.
  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    ser_start  = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE:      if (start) next_state = ST_HDR;
      ST_HDR,
      ST_LEN,
      ST_HI,
      ST_LO,
      ST_CSUM:      next_state = ST_ISSUE;
      ST_FETCH: begin
        rd_en      = 1'b1;
        next_state = ST_RD_WAIT;
      end
      ST_RD_WAIT:   next_state = ST_HI;
      ST_ISSUE: begin
        if (!ser_busy) begin
          ser_start  = 1'b1;
          next_state = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: if (ser_busy) next_state = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (!ser_busy) next_state = ret_state;
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default:      next_state = ST_IDLE;
    endcase
  end

  // Frame datapath: byte to send, where to go after it, checksum, address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ret_state <= ST_IDLE;
      len_r     <= '0;
      cnt       <= '0;
      addr      <= '0;
      csum      <= '0;
      byte_r    <= '0;
      word_r    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_r <= len;
            cnt   <= '0;
            addr  <= '0;
            csum  <= '0;
          end
        end
        ST_HDR: begin
          byte_r    <= HEADER_BYTE;
          ret_state <= ST_LEN;
        end
        ST_LEN: begin
          byte_r    <= len_r[7:0];
          csum      <= csum ^ len_r[7:0];
          ret_state <= (len_r == '0) ? ST_CSUM : ST_FETCH;
        end
        ST_RD_WAIT: word_r <= rd_data;
        ST_HI: begin
          byte_r    <= word_r[15:8];
          csum      <= csum ^ word_r[15:8];
          ret_state <= ST_LO;
        end
        ST_LO: begin
          byte_r <= word_r[7:0];
          csum   <= csum ^ word_r[7:0];
          cnt    <= cnt_next;
          // Hold the address on the last word so it never wraps past the end.
          if (cnt_next == len_r) begin
            ret_state <= ST_CSUM;
          end else begin
            ret_state <= ST_FETCH;
            addr      <= addr + ADDR_ONE;
          end
        end
        ST_CSUM: begin
          byte_r    <= csum;
          ret_state <= ST_DONE;
        end
        default: ;
      endcase
    end
  end

  assign rd_addr = addr;
  assign busy    = (state != ST_IDLE);

  uart_result_sender_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_tx (
    .clk      (clk),
    .reset    (reset),
    .tx_start (ser_start),
    .data_in  (byte_r),
    .tx       (tx),
    .tx_busy  (ser_busy)
  );

endmodule

// File: doc/uart_result_sender.md
UART_RESULT_SENDER -- requirements
Module: uart_result_sender

Interface
REQ-001 Parameters: DATA_W, default 16, result word width (fixed at 16; two bytes per word).
REQ-002 Parameters: ADDR_W, default 8, result-memory address width.
REQ-003 Parameters: CLK_FREQ, default 1000000, Hz, passed to serializer.
REQ-004 Parameters: BAUD_RATE, default 1000, passed to serializer.
REQ-005 clk  in  1  system clock, all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to transmit a result frame.
REQ-008 len  in  ADDR_W+1  word count, sampled on accepted start; 0..2^ADDR_W.
REQ-009 rd_en  out  1  result-memory read strobe.
REQ-010 rd_addr  out  ADDR_W  result-memory read address.
REQ-011 rd_data  in  DATA_W  read data, valid exactly 1 cycle after rd_en.
REQ-012 tx  out  1  UART serial line, idle high.
REQ-013 busy  out  1  high from accepted start until done.
REQ-014 done  out  1  one-cycle pulse when the frame's last stop bit completes.

Function
REQ-015 start accepted only in IDLE; start while busy=1 ignored, no queuing.
REQ-016 Frame byte order: 0xA5 header, len[7:0], per word rd_data[15:8] then rd_data[7:0] for addresses 0..len-1 ascending, then checksum.
REQ-017 Checksum = XOR of all frame bytes after header (len byte and all data bytes), 8-bit.
REQ-018 len=0: frame is A5, 00, 00; no rd_en issued.
REQ-019 len=2^ADDR_W: len byte carries len[7:0] (wraps to 0x00); all 2^ADDR_W words sent; rd_addr ends at 2^ADDR_W-1, no wrap beyond.
REQ-020 States: IDLE, HDR, LEN, FETCH, RD_WAIT, HI, LO, CSUM, ISSUE, WAIT_BUSY, WAIT_IDLE, DONE.
REQ-021 IDLE -> HDR on accepted start; len latched; address counter and checksum cleared.
REQ-022 Each byte send: ISSUE drives serializer data_in and one-cycle tx_start (only when serializer tx_busy=0); WAIT_BUSY until tx_busy=1; WAIT_IDLE until tx_busy=0; then return state register selects next step.
REQ-023 FETCH: rd_en=1 for one cycle at current address; RD_WAIT captures rd_data into a word register next cycle.
REQ-024 After LO: address increments; if words sent == len -> CSUM, else -> FETCH.
REQ-025 CSUM sent via same byte handshake, then DONE: done=1 one cycle, busy=0 from next cycle, -> IDLE.
REQ-026 Serializer tx_start never asserted while serializer tx_busy=1; exactly one tx_start per frame byte.
REQ-027 Inter-byte gap: at most 3 clk cycles of idle-high between a stop bit end and next start bit (excluding RD_WAIT, at most 5).
REQ-028 rd_en, done, serializer tx_start low in all states other than those stated.

Reset
REQ-029 reset asserted: state IDLE, busy=0, done=0, rd_en=0, rd_addr=0, tx=1 within the same asynchronous event; counters, checksum, word register cleared.
REQ-030 Reset mid-frame aborts the frame; no done pulse; next start after release begins a fresh frame with header.

Structure
REQ-031 Shared package holds the state enum, HEADER_BYTE=8'hA5, and bit-period helper constant.
REQ-032 One sub-module: the existing uart_tx serializer, instantiated once, sharing clk/reset, CLK_FREQ/BAUD_RATE forwarded.

Verification (CLK_FREQ=10, BAUD_RATE=1, 10 cycles/bit; memory model with 1-cycle latency)
REQ-033 len=2, mem[0]=0x1234, mem[1]=0xABCD -> tx bytes A5 02 12 34 AB CD 42, rd_addr 0 then 1, one done pulse.
REQ-034 len=0 -> bytes A5 00 00, rd_en never high, done pulse, busy low after.
REQ-035 len=1, mem[0]=0x00FF; start re-pulsed during byte 3 -> bytes A5 01 00 FF FE only, single done.
REQ-036 reset asserted during data byte 2 of len=2 frame -> tx=1 and busy=0 immediately, no done; subsequent start with len=1 mem[0]=0x0102 -> A5 01 01 02 02.
REQ-037 len=256 (ADDR_W=8), mem[i]=i -> len byte 00, 512 data bytes, rd_addr 0..255 monotonic, checksum matches XOR model.
REQ-038 Assertion throughout: no serializer tx_start while serializer tx_busy=1; busy=1 whenever tx not idle.
